// File: rtl/intr_ctrl_if.sv
// Bundle of controller-side signals between CSR/pipeline logic and intr_ctrl.
// Pure wiring, no latency.
// No backpressure; request is a level held until proc_ack.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
);
  logic [NUM_SRC-1:0] src_irq;
  logic               glb_en;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               proc_ack;
  logic               proc_done;
  logic               interrupt;
  logic [ID_W-1:0]    irq_id;
  logic [31:0]        irq_vec;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [15:0]        svc_cnt;

  // Processor / CSR side: drives sources, mask and handshake pulses.
  modport master (
    output src_irq, glb_en, mask_we, mask_wdata, proc_ack, proc_done,
    input  interrupt, irq_id, irq_vec, mask_q, pend_q, svc_cnt
  );

  // Controller side.
  modport slave (
    input  src_irq, glb_en, mask_we, mask_wdata, proc_ack, proc_done,
    output interrupt, irq_id, irq_vec, mask_q, pend_q, svc_cnt
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed lowest-index priority.
// Latency: source edge to interrupt level = 2 cycles.
// Request held as a level until proc_ack; new requests blocked until proc_done.
module intr_ctrl #(
  parameter int          NUM_SRC  = 8,
  parameter int          ID_W     = 3,
  parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
  input  logic      clk,
  input  logic      rst,
  intr_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state_q;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [31:0]        irq_vec_q;
  logic [15:0]        svc_cnt_q;

  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] cur_sel;
  logic [NUM_SRC-1:0] pend_clr;
  logic               cur_elig;
  logic               ack_take;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;

  assign src_edge = bus.src_irq & ~src_prev_q;
  assign elig     = bus.glb_en ? (pend_q & mask_q) : '0;
  assign cur_sel  = NUM_SRC'(1) << irq_id_q;
  assign cur_elig = |(elig & cur_sel);
  assign ack_take = (state_q == ST_REQ) && bus.proc_ack;
  assign pend_clr = ack_take ? cur_sel : '0;

  // Lowest eligible index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_vld = |elig;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  // Edge history, pending bits (a new edge beats a same-cycle ack clear) and mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
    end else begin
      src_prev_q <= bus.src_irq;
      pend_q     <= (pend_q & ~pend_clr) | src_edge;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

  // Request FSM: latch winner in IDLE, wait for ack or withdraw in REQ, wait for mret in SERVICE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      irq_vec_q <= VEC_BASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q   <= ST_REQ;
            irq_id_q  <= win_id;
            irq_vec_q <= VEC_BASE + (32'(win_id) << 2);
          end
        end
        ST_REQ: begin
          if (bus.proc_ack)   state_q <= ST_SERVICE;
          else if (!cur_elig) state_q <= ST_IDLE;
        end
        ST_SERVICE: begin
          if (bus.proc_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Count taken interrupts, sticking at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      svc_cnt_q <= '0;
    end else if (ack_take && (svc_cnt_q != 16'hFFFF)) begin
      svc_cnt_q <= svc_cnt_q + 16'd1;
    end
  end

  assign bus.interrupt = (state_q == ST_REQ);
  assign bus.irq_id    = irq_id_q;
  assign bus.irq_vec   = irq_vec_q;
  assign bus.mask_q    = mask_q;
  assign bus.pend_q    = pend_q;
  assign bus.svc_cnt   = svc_cnt_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset, basic path, priority, mask/withdraw,
// same-cycle set/clear, spurious handshakes and mid-service reset.
module tb_intr_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  intr_ctrl_if #(.NUM_SRC(8), .ID_W(3)) bus ();

  intr_ctrl #(
    .NUM_SRC (8),
    .ID_W    (3),
    .VEC_BASE(32'h0000_0080)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b0;
    bus.src_irq    = '0;
    bus.glb_en     = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.proc_ack   = 1'b0;
    bus.proc_done  = 1'b0;

    // Reset state
    #12;
    chk("rst_int",  {31'b0, bus.interrupt}, 32'h0);
    chk("rst_id",   {29'b0, bus.irq_id},    32'h0);
    chk("rst_vec",  bus.irq_vec,            32'h80);
    chk("rst_mask", {24'b0, bus.mask_q},    32'h0);
    chk("rst_pend", {24'b0, bus.pend_q},    32'h0);
    chk("rst_svc",  {16'b0, bus.svc_cnt},   32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Basic path on source 0
    bus.glb_en = 1'b1;
    set_mask(8'h01);
    chk("b_mask", {24'b0, bus.mask_q}, 32'h01);
    bus.src_irq = 8'h01;
    tick();
    bus.src_irq = 8'h00;
    chk("b_pend_k",  {24'b0, bus.pend_q},    32'h01);
    chk("b_int_k",   {31'b0, bus.interrupt}, 32'h0);
    tick();
    chk("b_int_k2",  {31'b0, bus.interrupt}, 32'h1);
    chk("b_id",      {29'b0, bus.irq_id},    32'h0);
    chk("b_vec",     bus.irq_vec,            32'h80);
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("b_int_ack", {31'b0, bus.interrupt}, 32'h0);
    chk("b_pend_ack",{24'b0, bus.pend_q},    32'h00);
    chk("b_svc",     {16'b0, bus.svc_cnt},   32'h1);
    tick();
    chk("b_svc_id",  {29'b0, bus.irq_id},    32'h0);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    chk("b_done_int",{31'b0, bus.interrupt}, 32'h0);

    // Priority: sources 5 and 2 together
    set_mask(8'hFF);
    bus.src_irq = 8'h24;
    tick();
    bus.src_irq = 8'h00;
    chk("p_pend", {24'b0, bus.pend_q}, 32'h24);
    tick();
    chk("p_int1", {31'b0, bus.interrupt}, 32'h1);
    chk("p_id1",  {29'b0, bus.irq_id},    32'h2);
    chk("p_vec1", bus.irq_vec,            32'h88);
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("p_pend1", {24'b0, bus.pend_q},  32'h20);
    chk("p_svc1",  {16'b0, bus.svc_cnt}, 32'h2);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    chk("p_idle",  {31'b0, bus.interrupt}, 32'h0);
    tick();
    chk("p_int2", {31'b0, bus.interrupt}, 32'h1);
    chk("p_id2",  {29'b0, bus.irq_id},    32'h5);
    chk("p_vec2", bus.irq_vec,            32'h94);
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("p_pend2", {24'b0, bus.pend_q},  32'h00);
    chk("p_svc2",  {16'b0, bus.svc_cnt}, 32'h3);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;

    // Masking and withdraw on source 3
    set_mask(8'h00);
    bus.src_irq = 8'h08;
    tick();
    bus.src_irq = 8'h00;
    chk("m_pend", {24'b0, bus.pend_q}, 32'h08);
    tick();
    chk("m_int_off", {31'b0, bus.interrupt}, 32'h0);
    set_mask(8'h08);
    chk("m_int_pre", {31'b0, bus.interrupt}, 32'h0);
    tick();
    chk("m_int_on", {31'b0, bus.interrupt}, 32'h1);
    chk("m_id",     {29'b0, bus.irq_id},    32'h3);
    chk("m_vec",    bus.irq_vec,            32'h8C);
    bus.glb_en = 1'b0;
    tick();
    chk("m_wd_int",  {31'b0, bus.interrupt}, 32'h0);
    chk("m_wd_pend", {24'b0, bus.pend_q},    32'h08);
    chk("m_wd_svc",  {16'b0, bus.svc_cnt},   32'h3);
    bus.glb_en = 1'b1;
    tick();
    chk("m_rereq", {31'b0, bus.interrupt}, 32'h1);
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("m_svc", {16'b0, bus.svc_cnt}, 32'h4);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;

    // Same-cycle new edge and ack on source 1
    set_mask(8'h02);
    bus.src_irq = 8'h02;
    tick();
    bus.src_irq = 8'h00;
    tick();
    chk("s_int", {31'b0, bus.interrupt}, 32'h1);
    chk("s_id",  {29'b0, bus.irq_id},    32'h1);
    bus.src_irq  = 8'h02;
    bus.proc_ack = 1'b1;
    tick();
    bus.src_irq  = 8'h00;
    bus.proc_ack = 1'b0;
    chk("s_pend", {24'b0, bus.pend_q},    32'h02);
    chk("s_int0", {31'b0, bus.interrupt}, 32'h0);
    chk("s_svc",  {16'b0, bus.svc_cnt},   32'h5);
    tick();
    chk("s_blocked", {31'b0, bus.interrupt}, 32'h0);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    tick();
    chk("s_rereq", {31'b0, bus.interrupt}, 32'h1);
    chk("s_reid",  {29'b0, bus.irq_id},    32'h1);
    chk("s_revec", bus.irq_vec,            32'h84);

    // Spurious handshakes: proc_done in REQ, proc_ack in IDLE
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    chk("x_done_req_int", {31'b0, bus.interrupt}, 32'h1);
    chk("x_done_req_svc", {16'b0, bus.svc_cnt},   32'h5);
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("x_ack_svc", {16'b0, bus.svc_cnt}, 32'h6);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("x_ack_idle_svc", {16'b0, bus.svc_cnt},   32'h6);
    chk("x_ack_idle_int", {31'b0, bus.interrupt}, 32'h0);

    // Reset while in SERVICE with another source pending
    bus.src_irq = 8'h82;
    tick();
    bus.src_irq = 8'h00;
    chk("r_pend", {24'b0, bus.pend_q}, 32'h82);
    tick();
    bus.proc_ack = 1'b1;
    tick();
    bus.proc_ack = 1'b0;
    chk("r_svc_pre",  {16'b0, bus.svc_cnt}, 32'h7);
    chk("r_pend_pre", {24'b0, bus.pend_q},  32'h80);
    rst = 1'b0;
    #1;
    chk("r_int",  {31'b0, bus.interrupt}, 32'h0);
    chk("r_pend0",{24'b0, bus.pend_q},    32'h00);
    chk("r_mask", {24'b0, bus.mask_q},    32'h00);
    chk("r_svc",  {16'b0, bus.svc_cnt},   32'h0);
    chk("r_vec",  bus.irq_vec,            32'h80);
    tick();
    rst = 1'b1;
    tick();
    chk("r_stay_idle", {31'b0, bus.interrupt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that drives the pipelined processor's single `interrupt` input.
- Latches rising edges from NUM_SRC peripheral sources into pending bits and applies a per-source mask plus a global enable.
- Picks the highest-priority pending source and holds a level request with a trap vector until the pipeline acknowledges it.
- Blocks further requests until the handler returns (mret). No nesting.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..16).
- ID_W, 3, width of source index; must satisfy 2**ID_W >= NUM_SRC.
- VEC_BASE, 32'h0000_0080, byte address of vector for source 0.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- src_irq  input  NUM_SRC  source lines, synchronous to clk, rising-edge sensitive.
- glb_en  input  1  global interrupt enable from CSR logic.
- mask_we  input  1  write strobe for mask register.
- mask_wdata  input  NUM_SRC  new mask value; 1 = enabled.
- proc_ack  input  1  one-cycle pulse: pipeline has flushed and taken the trap.
- proc_done  input  1  one-cycle pulse: mret retired.
- interrupt  output  1  level request to the processor.
- irq_id  output  ID_W  index of the requested/serviced source.
- irq_vec  output  32  trap target address.
- mask_q  output  NUM_SRC  current mask.
- pend_q  output  NUM_SRC  current pending bits.
- svc_cnt  output  16  count of acknowledged interrupts, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, interrupt=0, irq_id=0, irq_vec=VEC_BASE.
  - mask_q=0, pend_q=0, svc_cnt=0.
  - src_prev=0, so a source already high when reset releases is seen as an edge on the first clock.
- Edge detect: set pend[i] when src_irq[i]=1 and src_prev[i]=0. src_prev is updated every cycle.
- Mask: mask_q takes mask_wdata on the clk edge where mask_we=1. The new value is effective from the next cycle.
- Eligible vector: elig = pend_q & mask_q, gated by glb_en. Priority is fixed: lowest index wins.
- FSM state IDLE:
  - If elig != 0, go to REQ, latch irq_id = winning index and irq_vec = VEC_BASE + irq_id*4 (32-bit, no wrap check).
  - interrupt=1 from the cycle after the transition.
- FSM state REQ:
  - interrupt=1; irq_id and irq_vec are held stable.
  - On proc_ack: clear pend[irq_id], go to SERVICE, interrupt=0 from the next cycle, increment svc_cnt (saturating).
  - Withdraw: if the latched source loses eligibility without proc_ack (mask bit cleared or glb_en=0), return to IDLE and deassert interrupt; pend bit is kept.
  - proc_ack in the same cycle as loss of eligibility: ack wins.
- FSM state SERVICE:
  - interrupt=0; irq_id is held (identifies the active handler).
  - On proc_done, return to IDLE. A new request can be raised the cycle after that.
- Timing: a src edge sampled at edge k gives pend set after k, REQ after k+1, so interrupt=1 during cycle k+2. Minimum latency is 2 cycles.
- Simultaneous new edge on irq_id and proc_ack: set wins, so pend[irq_id] stays 1 and is re-requested after proc_done.
- Edges arriving while in REQ/SERVICE are latched and never lost. Repeated edges on an already-pending source merge into one pend bit.
- Ignored pulses (no state change): proc_ack in IDLE or SERVICE; proc_done in IDLE or REQ.
- Reset mid-operation (any state) returns everything to reset values immediately; pending interrupts are discarded.

Test Plan:
- Basic path: after reset, mask_we with mask_wdata=8'h01, glb_en=1, pulse src_irq[0] at edge k.
  - Required: interrupt=1 at k+2, irq_id=0, irq_vec=32'h80.
  - proc_ack gives interrupt=0 next cycle, pend_q=0, svc_cnt=1.
  - proc_done gives state IDLE.
- Priority: mask=8'hFF, raise src 5 and src 2 in the same cycle.
  - Required: irq_id=2, irq_vec=32'h88.
  - After ack and done, the second request has irq_id=5, irq_vec=32'h94, and pend_q=8'h00 after the second ack.
- Masking and withdraw: mask=8'h00, edge on src 3.
  - Required: pend_q=8'h08, interrupt stays 0.
  - Writing mask 8'h08 raises interrupt with irq_id=3.
  - Dropping glb_en before ack gives interrupt=0 next cycle with pend_q still 8'h08.
- Same-cycle set and clear: in REQ for src 1, a new src 1 edge coincides with proc_ack.
  - Required: pend_q[1]=1 after the edge.
  - After proc_done, a new request is raised with irq_id=1.
- Spurious handshakes and reset:
  - proc_ack in IDLE and proc_done in REQ cause no state change and leave svc_cnt unchanged.
  - Asserting rst=0 while in SERVICE immediately gives interrupt=0, pend_q=0, mask_q=0, svc_cnt=0.
